// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, ALU_OP codes.
// MC_CTRL_ADDI_EN adds the addi states to the state enum.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StJumpEx  = 4'd9
`ifdef MC_CTRL_ADDI_EN
    ,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_en;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_is_mem(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main control FSM.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;

  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       PCEn;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALU_OP;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCEn, PCSource, ALUSrcB, ALU_OP, illegal, state_o
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
           RegWrite, RegDst, PCEn, PCSource, ALUSrcB, ALU_OP, illegal, state_o
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of control state (plus mem_ready and Zero) to datapath controls.
// MC_CTRL_ADDI_EN adds the addi execute/writeback decodes.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBeqEx: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      StJumpEx: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      // Unused encodings drive nothing.
      default: ;
    endcase
    ctrl.pc_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register and next-state logic; outputs via mc_ctrl_outdec.
// MC_CTRL_ADDI_EN adds opcode 0x08 (addi) through ADDI_EX/ADDI_WB.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  state_e state_q, state_d;
  logic   illegal;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    illegal = 1'b0;
    case (state_q)
      StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (op_is_mem(bus.Op)) begin
          state_d = StMemAdr;
        end else begin
          case (bus.Op)
            OP_RTYPE: state_d = StRtypeEx;
            OP_BEQ:   state_d = StBeqEx;
            OP_J:     state_d = StJumpEx;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:  state_d = StAddiEx;
`endif
            default: begin
              illegal = 1'b1;
              state_d = StFetch;
            end
          endcase
        end
      end
      StMemAdr:  state_d = (bus.Op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   state_d = bus.mem_ready ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = bus.mem_ready ? StFetch : StMemWr;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StJumpEx:  state_d = StFetch;
`ifdef MC_CTRL_ADDI_EN
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
`endif
      default:   state_d = StFetch;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .zero      (bus.Zero),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.PCEn        = ctrl.pc_en;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALU_OP      = ctrl.alu_op;
  assign bus.illegal     = illegal;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-instruction expected state sequences and
// a per-state output table, plus literal checks on stalls, branches, illegal ops and reset.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected controls for a state number, packed as
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
  //  PCEn,PCSource[1:0],ALUSrcB[1:0],ALU_OP[1:0],illegal}
  function automatic logic [17:0] exp_out(int st, logic mr, logic z, logic [5:0] op);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, asa = 0;
    logic rw = 0, rd = 0, ill = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0;
    logic known;
    known = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) || (op == 6'h02);
`ifdef MC_CTRL_ADDI_EN
    known = known || (op == 6'h08);
`endif
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; ill = !known; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcw | (pcwc & z), pcs, asb, aop, ill};
  endfunction

  function automatic logic [17:0] dut_out();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
            bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.PCEn, bus.PCSource,
            bus.ALUSrcB, bus.ALU_OP, bus.illegal};
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Run one instruction from FETCH; fs/ms = mem_ready-low cycles in FETCH and in MEMRD/MEMWR.
  // Counts cover the cycles after FETCH.
  task automatic run(input string nm, input logic [5:0] op, input logic z, input int fs,
                     input int ms, output int cyc, output int pcw_n, output int rw_n,
                     output int mw_n, output int ill_n, output int pcen_n);
    int seq[$];
    bit rdy[$];
    logic [17:0] e, a;
    for (int i = 0; i < fs; i++) begin seq.push_back(0); rdy.push_back(0); end
    seq.push_back(0); rdy.push_back(1);
    seq.push_back(1); rdy.push_back(1);
    case (op)
      6'h23: begin
        seq.push_back(2); rdy.push_back(1);
        for (int i = 0; i < ms; i++) begin seq.push_back(3); rdy.push_back(0); end
        seq.push_back(3); rdy.push_back(1);
        seq.push_back(4); rdy.push_back(1);
      end
      6'h2B: begin
        seq.push_back(2); rdy.push_back(1);
        for (int i = 0; i < ms; i++) begin seq.push_back(5); rdy.push_back(0); end
        seq.push_back(5); rdy.push_back(1);
      end
      6'h00: begin seq.push_back(6); rdy.push_back(1); seq.push_back(7); rdy.push_back(1); end
      6'h04: begin seq.push_back(8); rdy.push_back(1); end
      6'h02: begin seq.push_back(9); rdy.push_back(1); end
`ifdef MC_CTRL_ADDI_EN
      6'h08: begin seq.push_back(10); rdy.push_back(1); seq.push_back(11); rdy.push_back(1); end
`endif
      default: ;
    endcase
    cyc = seq.size();
    pcw_n = 0; rw_n = 0; mw_n = 0; ill_n = 0; pcen_n = 0;
    for (int i = 0; i < seq.size(); i++) begin
      bus.Op = op;
      bus.Zero = z;
      bus.mem_ready = rdy[i];
      @(negedge clk);
      e = exp_out(seq[i], rdy[i], z, op);
      a = dut_out();
      tests++;
      if (int'(bus.state_o) != seq[i] || a !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: state %0d ctrl %h, expected state %0d ctrl %h",
                 nm, i, bus.state_o, a, seq[i], e);
      end
      if (seq[i] != 0) begin
        pcw_n += int'(bus.PCWrite);
        rw_n += int'(bus.RegWrite);
        ill_n += int'(bus.illegal);
        pcen_n += int'(bus.PCEn);
      end
      mw_n += int'(bus.MemWrite);
      @(posedge clk);
      #1;
    end
    check({nm, " back to fetch"}, int'(bus.state_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n;
    bus.Op = 6'h00;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("reset state", int'(bus.state_o), 0);
    check("reset MemRead", int'(bus.MemRead), 1);
    check("reset IRWrite", int'(bus.IRWrite), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run("lw", 6'h23, 1'b0, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("lw latency", cyc, 5);
    check("lw RegWrite cycles", rw_n, 1);

    run("rtype", 6'h00, 1'b1, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("rtype latency", cyc, 4);
    check("rtype RegWrite cycles", rw_n, 1);

    run("beq taken", 6'h04, 1'b1, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("beq taken PCEn", pcen_n, 1);
    check("beq latency", cyc, 3);
    run("beq not taken", 6'h04, 1'b0, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("beq not taken PCEn", pcen_n, 0);

    run("sw stall", 6'h2B, 1'b0, 0, 3, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("sw MemWrite cycles", mw_n, 4);
    check("sw total cycles", cyc, 7);
    check("sw RegWrite cycles", rw_n, 0);

    run("jump", 6'h02, 1'b0, 1, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("jump PCWrite cycles", pcw_n, 1);

    run("illegal 3F", 6'h3F, 1'b0, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("illegal 3F flag cycles", ill_n, 1);
    check("illegal 3F PCWrite", pcw_n, 0);
    check("illegal 3F RegWrite", rw_n, 0);
    check("illegal 3F latency", cyc, 2);

    run("op 08", 6'h08, 1'b0, 0, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
`ifdef MC_CTRL_ADDI_EN
    check("addi latency", cyc, 4);
    check("addi RegWrite cycles", rw_n, 1);
`else
    check("op 08 illegal cycles", ill_n, 1);
    check("op 08 RegWrite", rw_n, 0);
`endif

    run("lw mem stall", 6'h23, 1'b0, 2, 2, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("lw stall latency", cyc, 9);

    // Reset dropped while stalled in MEMRD.
    bus.Op = 6'h23;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("pre-reset state", int'(bus.state_o), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset state", int'(bus.state_o), 0);
    check("async reset MemRead", int'(bus.MemRead), 1);
    check("async reset IRWrite low", int'(bus.IRWrite), 0);
    bus.mem_ready = 1'b1;
    #1;
    check("reset IRWrite follows mem_ready", int'(bus.IRWrite), 1);
    @(posedge clk);
    #1;
    check("held in reset", int'(bus.state_o), 0);
    rst_n = 1'b1;

    run("lw after reset", 6'h23, 1'b0, 2, 0, cyc, pcw_n, rw_n, mw_n, ill_n, pcen_n);
    check("lw after reset latency", cyc, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode of the fetched instruction and sequences fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select, including the 2-bit `ALU_OP` consumed by `ALUControl`. Memory accesses use a ready handshake so that wait-state memories can stall the sequence.

## Interface
Parameters: none; all encodings come from the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- Op  in  6  opcode, instruction register bits [31:26]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  standard multicycle controls
- PCEn  out  1  `PCWrite | (PCWriteCond & Zero)`
- PCSource, ALUSrcB  out  2 each  mux selects
- ALU_OP  out  2  00 = add, 01 = subtract, 10 = use funct field
- illegal  out  1  unrecognised opcode seen in DECODE
- state_o  out  4  current state, for debug

## Operation
- State register: 4 bits, asynchronous reset to FETCH. All outputs are combinational decodes of the state, plus `mem_ready`, `Zero` and `Op` where noted.
- Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_OP=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALU_OP=00 to compute the branch target.
  - Next state by opcode: lw 0x23 / sw 0x2B -> MEMADR; R-type 0x00 -> RTYPE_EX; beq 0x04 -> BEQ_EX; j 0x02 -> JUMP_EX.
  - Any other opcode: `illegal`=1 for this cycle, next state FETCH.
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, ALU_OP=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: drives MemRead=1, IorD=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: drives RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR:
  - Drives MemWrite=1, IorD=1. Holds until `mem_ready`, then goes to FETCH.
  - MemWrite stays high for every stall cycle.
- RTYPE_EX: drives ALUSrcA=1, ALUSrcB=00, ALU_OP=10. Next state RTYPE_WB.
- RTYPE_WB: drives RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BEQ_EX: drives ALUSrcA=1, ALUSrcB=00, ALU_OP=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP_EX: drives PCWrite=1, PCSource=10. Next state FETCH.
- `Op` is sampled only in DECODE and MEMADR. The instruction register must not change outside FETCH.
- Unused state encodings go to FETCH on the next edge and assert no strobes.

## Timing
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal: 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. There is no timeout.
- The write strobes (PCWrite, IRWrite, RegWrite, MemWrite) take effect at the rising edge that ends the state.
- Reset asserted mid-instruction:
  - The state goes to FETCH immediately, asynchronously.
  - While `rst_n`=0, the outputs show the FETCH decode.
  - The datapath must be held in reset for the same period.
- First fetch after reset release: completes on the first edge at which `mem_ready`=1.
- `PCEn` is combinational from `Zero` in BEQ_EX. `Zero` must be stable before the edge.

## Configuration
- `MC_CTRL_ADDI_EN` defined:
  - Adds opcode 0x08 (addi). DECODE goes to ADDI_EX.
  - ADDI_EX drives ALUSrcA=1, ALUSrcB=10, ALU_OP=00, then goes to ADDI_WB.
  - ADDI_WB drives RegWrite=1, RegDst=0, MemtoReg=0, then goes to FETCH.
  - addi latency is 4 cycles.
- `MC_CTRL_ADDI_EN` not defined: 0x08 is illegal, and the ADDI states and their encodings do not exist.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the 4-bit state encodings (FETCH=0 through ADDI_WB=11)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALU_OP constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), shared with `ALUControl`
- One sub-module, `mc_ctrl_outdec`: purely combinational decode of state (plus mem_ready and Zero) to all control outputs. The top level holds only the state register and the next-state logic.

## Test plan
- Reset, then lw (Op=0x23) with `mem_ready`=1 -> state_o goes 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4; ALU_OP=00 throughout.
- R-type (Op=0x00) -> ALU_OP=10 in RTYPE_EX; RegDst=1 and RegWrite=1 in the next cycle; back in FETCH after 4 cycles.
- beq: Op=0x04 with Zero=1 -> PCEn=1, PCSource=01, ALU_OP=01 in BEQ_EX. Repeat with Zero=0 -> PCEn=0.
- sw (Op=0x2B) with `mem_ready` low for 3 cycles in MEMWR -> MemWrite high for 4 cycles; 7 cycles total; no RegWrite.
- Op=0x3F -> `illegal`=1 for one cycle in DECODE, then FETCH; no PCWrite or RegWrite. Repeat with Op=0x08 and the macro off -> same result.
- Drop `rst_n` in MEMRD -> state_o=0 at once with no clock edge; after release, IRWrite follows `mem_ready`. With `MC_CTRL_ADDI_EN` defined, Op=0x08 -> states 0,1,10,11,0.
